pc_hazard_controller: RTL

Pipeline hazard and stall controller for the 5-stage MIPS core. It decides each cycle whether the program counter and IF/ID register hold, whether ID/EX receives a bubble, and whether IF/ID is flushed. It covers load-use stalls, blocking multi-cycle multiply/divide, and taken branch/jump flushes. `pc_hold_o` drives the PC's enabler input directly: 1 = hold, 0 = load next PC.

---
 rtl/mips_pkg.sv | 13 +
 rtl/sat_counter.sv | 24 ++
 rtl/pc_hazard_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline control blocks.
// Holds the hazard FSM encoding, the zero-register index and the default mult/div latency.
package mips_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO          = 5'd0;
    localparam int         MULDIV_CYCLES_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// It updates on the falling edge so that it shares the PC register's timing.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count;

    always_ff @(negedge clk or negedge clr_n_i) begin
        if (!clr_n_i) begin
            count <= '0;
        end else if (inc_i && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign count_o = count;

endmodule

// File: rtl/pc_hazard_controller.sv
// Hazard and stall control for the 5-stage pipeline: load-use stalls, blocking mult/div
// waits and branch/jump flushes. State advances on negedge clk, in step with the PC.
module pc_hazard_controller
    import mips_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int CNT_BITS      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          id_rs_i,
    input  logic [4:0]          id_rt_i,
    input  logic                id_uses_rt_i,
    input  logic                ex_mem_read_i,
    input  logic [4:0]          ex_rt_i,
    input  logic                id_muldiv_i,
    input  logic                branch_taken_i,
    input  logic                jump_i,
    output logic                pc_hold_o,
    output logic                ifid_hold_o,
    output logic                idex_bubble_o,
    output logic                ifid_flush_o,
    output logic                busy_o,
    output logic [CNT_BITS-1:0] stall_cycles_o
);

    localparam int              MD_W    = $clog2(MULDIV_CYCLES + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES - 1);

    hz_state_t       state;
    logic [MD_W-1:0] md_cnt;
    logic            load_use;
    logic            md_start;
    logic            hold;
    logic            flush;

    assign load_use = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    // Outputs are forced low while reset is asserted, whatever the inputs do.
    always_comb begin
        hold     = 1'b0;
        flush    = 1'b0;
        md_start = 1'b0;
        if (reset) begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        hold = 1'b1;
                    end else if (id_muldiv_i) begin
                        md_start = 1'b1;
                    end else if (branch_taken_i || jump_i) begin
                        flush = 1'b1;
                    end
                end
                MD_WAIT: hold = 1'b1;
                default: hold = 1'b0;
            endcase
        end
    end

    // MD_WAIT lasts md_cnt+1 cycles from entry, so loading MULDIV_CYCLES-1 gives the full occupancy.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (md_start) begin
                        state  <= MD_WAIT;
                        md_cnt <= MD_LOAD;
                    end
                end
                MD_WAIT: begin
                    if (md_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        md_cnt <= md_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    assign pc_hold_o     = hold;
    assign ifid_hold_o   = hold;
    assign idex_bubble_o = hold;
    assign ifid_flush_o  = flush;
    assign busy_o        = reset && (state == MD_WAIT);

    sat_counter #(
        .WIDTH(CNT_BITS)
    ) u_stall_cnt (
        .clk    (clk),
        .clr_n_i(reset),
        .inc_i  (hold),
        .count_o(stall_cycles_o)
    );

endmodule
